llsc_resv_ctrl: RTL and testbench

//  Controller for the LL/SC atomic reservation.
//  - Sequences the LLbit from the pipeline's LL, SC, store-snoop and flush events.
//  - Holds the reserved address granule.
//  - Decides the SC outcome in the MEM stage.

---
 rtl/llsc_resv_ctrl.sv | 100 ++++++++++
 tb/tb_llsc_resv_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/llsc_resv_ctrl.sv
// LL/SC reservation controller: owns the LLbit and the reserved address granule, and
// resolves SC success combinationally in MEM. Optional stale-reservation timeout: LLSC_TIMEOUT_EN.
module llsc_resv_ctrl #(
    parameter int GRAN_BITS  = 4,
    parameter int TMO_CYCLES = 256,
    parameter int TMO_W      = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ll_valid,
    input  logic [31:0] ll_addr,
    input  logic        sc_valid,
    input  logic [31:0] sc_addr,
    input  logic        snoop_valid,
    input  logic [31:0] snoop_addr,
    output logic        sc_success,
    output logic        LLbit_o,
    output logic [31:0] resv_addr_o
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] RESERVED = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [31:GRAN_BITS]   resv_gran_q, resv_gran_d;
    logic                  sc_match;
    logic                  snoop_hit;

    // Only granule bits participate in matching; the offset bits are deliberately dropped.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{ll_addr[GRAN_BITS-1:0], sc_addr[GRAN_BITS-1:0],
                                  snoop_addr[GRAN_BITS-1:0]};

    assign sc_match  = (sc_addr[31:GRAN_BITS] == resv_gran_q);
    assign snoop_hit = snoop_valid && (snoop_addr[31:GRAN_BITS] == resv_gran_q);

    // A same-cycle matching store or a flush beats the SC to the granule.
    assign sc_success = rst && sc_valid && (state_q == RESERVED) && sc_match
                        && !flush && !snoop_hit;

    assign LLbit_o     = (state_q == RESERVED);
    assign resv_addr_o = {resv_gran_q, {GRAN_BITS{1'b0}}};

`ifdef LLSC_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_expire;

    assign tmo_expire = (state_q == RESERVED) && (tmo_cnt_q == TMO_W'(TMO_CYCLES - 1));
`endif

    always_comb begin
        state_d     = state_q;
        resv_gran_d = resv_gran_q;
`ifdef LLSC_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        if (flush) begin
            state_d = IDLE;
        end else if (sc_valid) begin
            state_d = IDLE;
        end else if (ll_valid) begin
            state_d     = RESERVED;
            resv_gran_d = ll_addr[31:GRAN_BITS];
`ifdef LLSC_TIMEOUT_EN
            tmo_cnt_d   = '0;
`endif
        end else if (snoop_hit && (state_q == RESERVED)) begin
            state_d = IDLE;
`ifdef LLSC_TIMEOUT_EN
        end else if (tmo_expire) begin
            state_d = IDLE;
        end else if (state_q == RESERVED) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
`endif
        end
`ifdef LLSC_TIMEOUT_EN
        if (state_d == IDLE) begin
            tmo_cnt_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            resv_gran_q <= '0;
`ifdef LLSC_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            resv_gran_q <= resv_gran_d;
`ifdef LLSC_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_llsc_resv_ctrl.sv
// Directed vector bench for llsc_resv_ctrl: per-cycle input records with the expected
// same-cycle sc_success and the LLbit/address after the following edge.
module tb_llsc_resv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ll_valid;
    logic [31:0] ll_addr;
    logic        sc_valid;
    logic [31:0] sc_addr;
    logic        snoop_valid;
    logic [31:0] snoop_addr;
    logic        sc_success;
    logic        LLbit_o;
    logic [31:0] resv_addr_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    llsc_resv_ctrl #(.GRAN_BITS(4), .TMO_CYCLES(8), .TMO_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .ll_valid    (ll_valid),
        .ll_addr     (ll_addr),
        .sc_valid    (sc_valid),
        .sc_addr     (sc_addr),
        .snoop_valid (snoop_valid),
        .snoop_addr  (snoop_addr),
        .sc_success  (sc_success),
        .LLbit_o     (LLbit_o),
        .resv_addr_o (resv_addr_o)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        flush;
        logic        ll_v;
        logic [31:0] ll_a;
        logic        sc_v;
        logic [31:0] sc_a;
        logic        sn_v;
        logic [31:0] sn_a;
        logic        exp_sc;
        logic        exp_ll;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic f, input logic llv, input logic [31:0] lla,
                         input logic scv, input logic [31:0] sca,
                         input logic snv, input logic [31:0] sna);
        rst = r; flush = f;
        ll_valid = llv; ll_addr = lla;
        sc_valid = scv; sc_addr = sca;
        snoop_valid = snv; snoop_addr = sna;
    endtask

    task automatic add(input string nm, input logic r, input logic f,
                       input logic llv, input logic [31:0] lla,
                       input logic scv, input logic [31:0] sca,
                       input logic snv, input logic [31:0] sna,
                       input logic esc, input logic ell, input logic [31:0] ea);
        vec_t v;
        v.name = nm; v.rst = r; v.flush = f;
        v.ll_v = llv; v.ll_a = lla; v.sc_v = scv; v.sc_a = sca;
        v.sn_v = snv; v.sn_a = sna;
        v.exp_sc = esc; v.exp_ll = ell; v.exp_addr = ea;
        vq.push_back(v);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        //   name            rst fl  llv ll_a          scv sc_a          snv sn_a          sc  ll  addr
        add("rst_a",         0,  1,  1,  32'h1234_5678, 1, 32'h1234_5678, 1, 32'h0000_0000, 0,  0,  32'h0);
        add("rst_b",         0,  0,  1,  32'hFFFF_FFFF, 1, 32'h0000_0000, 1, 32'hFFFF_FFF0, 0,  0,  32'h0);
        add("sc_idle",       1,  0,  0,  32'h0,         1, 32'h0000_0000, 0, 32'h0,         0,  0,  32'h0);
        add("ll1",           1,  0,  1,  32'h1000_0048, 0, 32'h0,         0, 32'h0,         0,  1,  32'h1000_0040);
        add("sc_pass",       1,  0,  0,  32'h0,         1, 32'h1000_004C, 0, 32'h0,         1,  0,  32'h1000_0040);
        add("ll2",           1,  0,  1,  32'h1000_0048, 0, 32'h0,         0, 32'h0,         0,  1,  32'h1000_0040);
        add("snoop_miss",    1,  0,  0,  32'h0,         0, 32'h0,         1, 32'h1000_0050, 0,  1,  32'h1000_0040);
        add("snoop_hit",     1,  0,  0,  32'h0,         0, 32'h0,         1, 32'h1000_0040, 0,  0,  32'h1000_0040);
        add("sc_after_snp",  1,  0,  0,  32'h0,         1, 32'h1000_0048, 0, 32'h0,         0,  0,  32'h1000_0040);
        add("ll3",           1,  0,  1,  32'h1000_0048, 0, 32'h0,         0, 32'h0,         0,  1,  32'h1000_0040);
        add("flush_sc",      1,  1,  0,  32'h0,         1, 32'h1000_0048, 0, 32'h0,         0,  0,  32'h1000_0040);
        add("snoop_idle",    1,  0,  0,  32'h0,         0, 32'h0,         1, 32'h1000_0040, 0,  0,  32'h1000_0040);
        add("ll4",           1,  0,  1,  32'h1000_0048, 0, 32'h0,         0, 32'h0,         0,  1,  32'h1000_0040);
        add("ll_snp_old",    1,  0,  1,  32'h1000_0044, 0, 32'h0,         1, 32'h1000_0040, 0,  1,  32'h1000_0040);
        add("ll_snp_new",    1,  0,  1,  32'h2000_0010, 0, 32'h0,         1, 32'h2000_0010, 0,  1,  32'h2000_0010);
        add("rearm",         1,  0,  1,  32'h3000_00FF, 0, 32'h0,         0, 32'h0,         0,  1,  32'h3000_00F0);
        add("sc_old_gran",   1,  0,  0,  32'h0,         1, 32'h2000_0010, 0, 32'h0,         0,  0,  32'h3000_00F0);
        add("ll5",           1,  0,  1,  32'h4000_0000, 0, 32'h0,         0, 32'h0,         0,  1,  32'h4000_0000);
        add("sc_ll_same",    1,  0,  1,  32'h5000_0000, 1, 32'h4000_0004, 0, 32'h0,         1,  0,  32'h4000_0000);
        add("ll6",           1,  0,  1,  32'h6000_0020, 0, 32'h0,         0, 32'h0,         0,  1,  32'h6000_0020);
        add("sc_snp_same",   1,  0,  0,  32'h0,         1, 32'h6000_0028, 1, 32'h6000_002C, 0,  0,  32'h6000_0020);
        add("ll7",           1,  0,  1,  32'h7000_0000, 0, 32'h0,         0, 32'h0,         0,  1,  32'h7000_0000);
        add("sc_mismatch",   1,  0,  0,  32'h0,         1, 32'h7000_0010, 0, 32'h0,         0,  0,  32'h7000_0000);
        add("ll8",           1,  0,  1,  32'h8000_0000, 0, 32'h0,         0, 32'h0,         0,  1,  32'h8000_0000);
        add("rst_resv",      0,  0,  0,  32'h0,         1, 32'h8000_0000, 0, 32'h0,         0,  0,  32'h0);

        @(posedge clk); #1;
        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].flush, vq[i].ll_v, vq[i].ll_a,
                  vq[i].sc_v, vq[i].sc_a, vq[i].sn_v, vq[i].sn_a);
            @(negedge clk);
            chk({vq[i].name, ".sc_success"}, {31'b0, sc_success}, {31'b0, vq[i].exp_sc});
            @(posedge clk); #1;
            chk({vq[i].name, ".LLbit_o"}, {31'b0, LLbit_o}, {31'b0, vq[i].exp_ll});
            chk({vq[i].name, ".resv_addr_o"}, resv_addr_o, vq[i].exp_addr);
        end

        // Reservation lifetime with no further events.
        drive(1'b1, 1'b0, 1'b1, 32'h9000_0008, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("life.ll_set", {31'b0, LLbit_o}, 32'd1);
`ifdef LLSC_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            chk($sformatf("tmo.edge%0d", k), {31'b0, LLbit_o}, (k < 8) ? 32'd1 : 32'd0);
        end
`else
        for (int k = 1; k <= 1000; k++) begin
            @(posedge clk); #1;
            if (LLbit_o !== 1'b1 || k == 1000)
                chk($sformatf("persist.cycle%0d", k), {31'b0, LLbit_o}, 32'd1);
        end
`endif

        // Back-to-back LL then SC, then a late SC to the same granule must fail.
        drive(1'b1, 1'b0, 1'b1, 32'hA000_0030, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_003F, 1'b0, 32'h0);
        @(negedge clk);
        chk("b2b.sc_success", {31'b0, sc_success}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b.sc_again", {31'b0, sc_success}, 32'd0);
        @(posedge clk); #1;
        chk("b2b.LLbit_o", {31'b0, LLbit_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
